instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential MIPS instruction encoder and instruction-memory loader, the inverse of the main/ALU decoder. It accepts mnemonic-plus-field requests over a valid/ready handshake, packs them into 32-bit instruction words using exactly the opcode/funct encodings the decoder recognises, and writes them to consecutive instruction-memory words through a registered write port. It sits between the testbench/boot loader and imem, so programs can be generated symbolically and decoded back by the controller.

## Interface
- AW, 6, imem address width in words; depth = 2**AW
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- start  in  1  pulse: load write address from base_addr, clear count, enter RUN
- base_addr  in  AW  first word address for this program
- finish  in  1  pulse: end program, return to IDLE
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- mnem  in  4  mnemonic (mnem_t): ADD, SUB, AND, OR, SLT, J, JR, JAL, LW, SW, BEQ, BNE, ADDI, ANDI, ORI, SLTI
- rs, rt, rd  in  5 each  register fields
- imm  in  16  immediate / branch operand
- target  in  26  jump target field
- imem_we  out  1  write strobe
- imem_waddr  out  AW  write word address
- imem_wdata  out  32  encoded instruction
- count  out  AW+1  words written since start
- full  out  1  last address written; no further accepts
- err  out  1  one-cycle pulse: request rejected
- done  out  1  one-cycle pulse on finish

## Operation
- States: IDLE, RUN, FULL. Reset -> IDLE.
- IDLE: in_ready=0. start -> RUN.
- RUN: in_ready=1. finish -> IDLE, done=1 next cycle. Acceptance that targets address base_addr+k where count+1 reaches depth-base_addr (i.e. address 2**AW-1) -> FULL.
- FULL: in_ready=0, full=1. finish -> IDLE with done; start -> RUN (full cleared).
- start and finish same cycle: start wins, done not pulsed. start in RUN/FULL restarts; no done.
- Encoding: R-type op 000000, shamt 0, funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010. J 000010 / JAL 000011 {op,target}. JR op 001000, rs field, rt=rd=imm=0. LW 100011, SW 101011, BEQ 000100, BNE 000101, ANDI 001100, ORI 001101, SLTI 001010 as {op,rs,rt,imm}.
- ADDI shares op 001000 with JR in the decoder, so ADDI is rejected: no write, count unchanged, err pulse. Same for any undefined mnem code.
- Address counter increments by 1 per written word; never wraps (FULL stops it).

## Timing
- Reset values: in_ready 0, imem_we 0, imem_waddr 0, imem_wdata 0, count 0, full 0, err 0, done 0.
- Latency 1: request accepted at edge N -> imem_we=1 with waddr/wdata during cycle N+1; count increments at edge N.
- Back-to-back accepts give one write per cycle.
- err asserted cycle N+1 for a rejected request accepted at edge N; imem_we stays 0.
- A write registered before start/finish still completes in the following cycle.
- Reset mid-operation: imem_we drops at the reset edge; no partial write.

## Configuration
- ENC_BRANCH_REL_EN defined: for BEQ/BNE, imm is an absolute word address; encoded offset = imm - (waddr+1), waddr zero-extended to 16 bits, result truncated to 16 bits two's complement.
- Undefined: imm passed verbatim into the branch offset field.

## Structure
- mips_pkg: mnem_t enum, opcode and funct localparams, state enum; shared with the decoder.
- Sub-module instr_pack: combinational {mnem, fields} -> {word, illegal}; top holds FSM, address counter, output register.

## Test plan
- reset low 2 cycles, then start base 0, ADD rs=1 rt=2 rd=3 -> next cycle we=1, waddr 0, wdata 0x00221820, count 1.
- LW rt=2 rs=0 imm=4 then J target=0x11 back-to-back -> waddr 0/1, wdata 0x8C020004 then 0x08000011.
- JR rs=31 -> 0x23E00000; ADDI -> err pulse, no write, count unchanged.
- Macro on: start base 5, BEQ rs=1 rt=2 imm=2 -> wdata 0x1022FFFC; macro off, imm=0xFFFC -> same word.
- AW=2, start base 0, 4 accepts -> full=1, in_ready=0 after 4th; 5th held; finish -> done pulse, IDLE.
- start and finish together in RUN -> counter reset to base, no done; reset low mid-burst -> all outputs to reset values.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: mnemonic codes, opcode/funct encodings and encoder FSM states.
// These encodings are the ones the main/ALU decoder recognises.
package mips_pkg;

    typedef enum logic [3:0] {
        MN_ADD  = 4'd0,
        MN_SUB  = 4'd1,
        MN_AND  = 4'd2,
        MN_OR   = 4'd3,
        MN_SLT  = 4'd4,
        MN_J    = 4'd5,
        MN_JR   = 4'd6,
        MN_JAL  = 4'd7,
        MN_LW   = 4'd8,
        MN_SW   = 4'd9,
        MN_BEQ  = 4'd10,
        MN_BNE  = 4'd11,
        MN_ADDI = 4'd12,
        MN_ANDI = 4'd13,
        MN_ORI  = 4'd14,
        MN_SLTI = 4'd15
    } mnem_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JR    = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational packing of a mnemonic plus fields into a 32-bit
// MIPS word. ADDI is flagged illegal because the decoder maps its opcode to JR.
// Optional macro ENC_BRANCH_REL_EN: BEQ/BNE imm is an absolute word address
// turned into a PC-relative offset using the word's write address.
module instr_pack
    import mips_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic [3:0]    mnem,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
`ifdef ENC_BRANCH_REL_EN
    input  logic [AW-1:0] waddr,
`endif
    output logic [31:0]   word,
    output logic          illegal
);

    logic [15:0] br_off_s;

`ifdef ENC_BRANCH_REL_EN
    // Branch offset is relative to the word after the branch itself.
    assign br_off_s = imm - (16'(waddr) + 16'd1);
`else
    assign br_off_s = imm;
`endif

    // Select opcode/funct layout for the requested mnemonic.
    always_comb begin
        word    = 32'd0;
        illegal = 1'b0;
        case (mnem_t'(mnem))
            MN_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
            MN_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
            MN_AND:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            MN_OR:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            MN_SLT:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
            MN_J:    word = {OP_J, target};
            MN_JAL:  word = {OP_JAL, target};
            MN_JR:   word = {OP_JR, rs, 5'd0, 16'd0};
            MN_LW:   word = {OP_LW, rs, rt, imm};
            MN_SW:   word = {OP_SW, rs, rt, imm};
            MN_BEQ:  word = {OP_BEQ, rs, rt, br_off_s};
            MN_BNE:  word = {OP_BNE, rs, rt, br_off_s};
            MN_ANDI: word = {OP_ANDI, rs, rt, imm};
            MN_ORI:  word = {OP_ORI, rs, rt, imm};
            MN_SLTI: word = {OP_SLTI, rs, rt, imm};
            MN_ADDI: illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts encode requests over valid/ready, writes packed words
// to consecutive imem addresses through a registered write port.
// Optional macro ENC_BRANCH_REL_EN (see instr_pack) selects relative branches.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    mnem,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err,
    output logic          done
);

    state_t        state_r;
    logic [AW-1:0] addr_r;
    logic [AW:0]   count_r;
    logic          we_r;
    logic [AW-1:0] waddr_r;
    logic [31:0]   wdata_r;
    logic          err_r;
    logic          done_r;

    logic [31:0]   word_s;
    logic          illegal_s;
    logic          accept_s;

    instr_pack #(.AW(AW)) u_pack (
        .mnem    (mnem),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .imm     (imm),
        .target  (target),
`ifdef ENC_BRANCH_REL_EN
        .waddr   (addr_r),
`endif
        .word    (word_s),
        .illegal (illegal_s)
    );

    assign accept_s = in_valid && (state_r == ST_RUN);

    // Control FSM, address/word counter and registered imem write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            addr_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
            we_r    <= 1'b0;
            waddr_r <= {AW{1'b0}};
            wdata_r <= 32'd0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            we_r   <= 1'b0;
            err_r  <= 1'b0;
            done_r <= 1'b0;
            // A handshake completed this cycle is always honoured.
            if (accept_s) begin
                if (illegal_s) begin
                    err_r <= 1'b1;
                end else begin
                    we_r    <= 1'b1;
                    waddr_r <= addr_r;
                    wdata_r <= word_s;
                end
            end
            // start has priority over finish; both override the counters.
            if (start) begin
                state_r <= ST_RUN;
                addr_r  <= base_addr;
                count_r <= {(AW+1){1'b0}};
            end else if (finish) begin
                state_r <= ST_IDLE;
                done_r  <= (state_r != ST_IDLE);
            end else if (accept_s && !illegal_s) begin
                count_r <= count_r + {{AW{1'b0}}, 1'b1};
                if (addr_r == {AW{1'b1}}) begin
                    state_r <= ST_FULL;
                end else begin
                    addr_r <= addr_r + {{(AW-1){1'b0}}, 1'b1};
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign in_ready   = (state_r == ST_RUN);
    assign full       = (state_r == ST_FULL);
    assign imem_we    = we_r;
    assign imem_waddr = waddr_r;
    assign imem_wdata = wdata_r;
    assign count      = count_r;
    assign err        = err_r;
    assign done       = done_r;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scoreboard bench for instr_encoder (AW=6 and AW=2).
module tb_instr_encoder;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, finish, in_valid;
    logic [5:0]  base_addr;
    logic [3:0]  mnem;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        in_ready, imem_we, full, err, done;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [6:0]  count;

    logic        start2, finish2, valid2;
    logic [1:0]  base2;
    logic        ready2, we2, full2, err2, done2;
    logic [1:0]  waddr2;
    logic [31:0] wdata2;
    logic [2:0]  count2;

    int checks = 0;
    int errors = 0;
    logic [37:0] sb[$];

    always #5 clk = ~clk;

    instr_encoder #(.AW(6)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err), .done(done)
    );

    instr_encoder #(.AW(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .base_addr(base2),
        .finish(finish2), .in_valid(valid2), .in_ready(ready2),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .imem_we(we2), .imem_waddr(waddr2), .imem_wdata(wdata2),
        .count(count2), .full(full2), .err(err2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input mnem_t m, input logic [4:0] s, input logic [4:0] t,
                           input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg);
        mnem = m; rs = s; rt = t; rd = d; imm = i; target = tg;
    endtask

    // Drive one request to the main DUT, expect its write right after the edge.
    task automatic req_write(input mnem_t m, input logic [4:0] s, input logic [4:0] t,
                             input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg,
                             input logic [5:0] ea, input logic [31:0] ew);
        logic [37:0] e;
        set_req(m, s, t, d, i, tg);
        in_valid = 1'b1;
        sb.push_back({ea, ew});
        tick();
        chk("we", {31'd0, imem_we}, 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow observed empty expected entry");
        end else begin
            e = sb.pop_front();
            chk("waddr", {26'd0, imem_waddr}, {26'd0, e[37:32]});
            chk("wdata", imem_wdata, e[31:0]);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_waddr", {26'd0, imem_waddr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_count", {25'd0, count}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0; base_addr = 6'd0;
        start2 = 1'b0; finish2 = 1'b0; valid2 = 1'b0; base2 = 2'd0;
        set_req(MN_ADD, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        tick(); tick();
        chk_reset_vals();
        reset = 1'b1;
        tick();
        chk("idle_ready", {31'd0, in_ready}, 32'd0);

        // start base 0, single ADD
        start = 1'b1; base_addr = 6'd0; tick(); start = 1'b0;
        chk("run_ready", {31'd0, in_ready}, 32'd1);
        req_write(MN_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 6'd0, 32'h00221820);
        chk("cnt_add", {25'd0, count}, 32'd1);
        in_valid = 1'b0; tick();
        chk("we_idle", {31'd0, imem_we}, 32'd0);

        // restart in RUN: no done, back-to-back LW then J
        start = 1'b1; base_addr = 6'd0; tick(); start = 1'b0;
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_cnt", {25'd0, count}, 32'd0);
        req_write(MN_LW, 5'd0, 5'd2, 5'd0, 16'd4, 26'd0, 6'd0, 32'h8C020004);
        req_write(MN_J, 5'd0, 5'd0, 5'd0, 16'd0, 26'h11, 6'd1, 32'h08000011);
        req_write(MN_JR, 5'd31, 5'd7, 5'd9, 16'h5555, 26'd0, 6'd2, 32'h23E00000);
        req_write(MN_SUB, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 6'd3, 32'h00853022);
        req_write(MN_ORI, 5'd3, 5'd4, 5'd0, 16'h1234, 26'd0, 6'd4, 32'h34641234);
        chk("cnt5", {25'd0, count}, 32'd5);

        // ADDI rejected
        set_req(MN_ADDI, 5'd1, 5'd2, 5'd0, 16'd7, 26'd0);
        tick();
        chk("addi_err", {31'd0, err}, 32'd1);
        chk("addi_we", {31'd0, imem_we}, 32'd0);
        chk("addi_cnt", {25'd0, count}, 32'd5);
        in_valid = 1'b0; tick();
        chk("err_pulse", {31'd0, err}, 32'd0);

        // finish -> done pulse, IDLE
        finish = 1'b1; tick(); finish = 1'b0;
        chk("done1", {31'd0, done}, 32'd1);
        chk("fin_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("done0", {31'd0, done}, 32'd0);

        // branch at base 5
        start = 1'b1; base_addr = 6'd5; tick(); start = 1'b0;
`ifdef ENC_BRANCH_REL_EN
        req_write(MN_BEQ, 5'd1, 5'd2, 5'd0, 16'd2, 26'd0, 6'd5, 32'h1022FFFC);
`else
        req_write(MN_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFC, 26'd0, 6'd5, 32'h1022FFFC);
`endif
        in_valid = 1'b0; tick();

        // start and finish together: start wins, no done
        start = 1'b1; finish = 1'b1; base_addr = 6'd8; tick();
        start = 1'b0; finish = 1'b0;
        chk("sf_done", {31'd0, done}, 32'd0);
        chk("sf_cnt", {25'd0, count}, 32'd0);
        chk("sf_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("sf_done2", {31'd0, done}, 32'd0);
        req_write(MN_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 6'd8, 32'h00221820);
        in_valid = 1'b0;

        // AW=2 instance: fill to FULL
        set_req(MN_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        start2 = 1'b1; base2 = 2'd0; tick(); start2 = 1'b0;
        valid2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s_we", {31'd0, we2}, 32'd1);
            chk("s_waddr", {30'd0, waddr2}, k);
        end
        chk("s_full", {31'd0, full2}, 32'd1);
        chk("s_ready", {31'd0, ready2}, 32'd0);
        chk("s_cnt", {29'd0, count2}, 32'd4);
        tick();
        chk("s_held_we", {31'd0, we2}, 32'd0);
        chk("s_held_cnt", {29'd0, count2}, 32'd4);
        valid2 = 1'b0;
        finish2 = 1'b1; tick(); finish2 = 1'b0;
        chk("s_done", {31'd0, done2}, 32'd1);
        chk("s_full0", {31'd0, full2}, 32'd0);
        chk("s_idle", {31'd0, ready2}, 32'd0);

        // reset mid-burst
        start = 1'b1; base_addr = 6'd3; tick(); start = 1'b0;
        req_write(MN_AND, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 6'd3, 32'h00221824);
        reset = 1'b0;
        tick();
        chk_reset_vals();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("post_rst_we", {31'd0, imem_we}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
